// File: rtl/ex_logic_shift_unit.sv
// EX-stage logic/shift unit: bitwise ops and LUI with a one-cycle registered
// result, SLL/SRL/SRA on an iterative shifter moving up to STEP bits per
// cycle. Valid/ready handshake on issue and writeback, synchronous flush.
module ex_logic_shift_unit #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int STEP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int AW = $clog2(WIDTH);
    // One extra bit so STEP == WIDTH is still representable
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_NOR = 4'd3,
        OP_LUI = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7
    } op_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic [CW-1:0]     rem_q, rem_d;
    kind_t             kind_q, kind_d;
    logic              sign_q, sign_d;

    logic              accept;
    logic [CW-1:0]     amt;
    logic [CW-1:0]     first_d;
    logic [CW-1:0]     cont_d;
    logic              iss_shift;
    kind_t             iss_kind;
    logic [WIDTH-1:0]  iss_result;
    logic [CW-1:0]     iss_rem;
    state_t            iss_state;

    // One shifter step of d bits; SRA fills with the sign captured at issue
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input kind_t            k,
        input logic             s,
        input logic [CW-1:0]    d
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        ones = '1;
        fill = s ? ~(ones >> d) : '0;
        case (k)
            K_SLL:   r = v << d;
            K_SRL:   r = v >> d;
            default: r = (v >> d) | fill;
        endcase
        return r;
    endfunction

    // Handshake outputs derived directly from state and reset
    always_comb begin
        in_ready = !rst && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
        busy     = (state_q != S_IDLE);
        accept   = in_valid && in_ready && !flush;
    end

    // Result and shifter setup for an operation presented on the issue port
    always_comb begin
        amt        = {1'b0, src1[AW-1:0]};
        first_d    = (amt > STEP_C) ? STEP_C : amt;
        cont_d     = (rem_q > STEP_C) ? STEP_C : rem_q;
        iss_shift  = 1'b0;
        iss_kind   = K_SLL;
        iss_result = '0;
        iss_rem    = '0;
        case (op_t'(op))
            OP_AND: iss_result = src0 & src1;
            OP_OR:  iss_result = src0 | src1;
            OP_XOR: iss_result = src0 ^ src1;
            OP_NOR: iss_result = ~(src0 | src1);
            OP_LUI: iss_result = src1 << (WIDTH - IMM_WIDTH);
            OP_SLL: begin iss_shift = 1'b1; iss_kind = K_SLL; end
            OP_SRL: begin iss_shift = 1'b1; iss_kind = K_SRL; end
            OP_SRA: begin iss_shift = 1'b1; iss_kind = K_SRA; end
            default: iss_result = '0;
        endcase
        if (iss_shift) begin
            iss_result = shift_step(src0, iss_kind, src0[WIDTH-1], first_d);
            iss_rem    = amt - first_d;
        end
        iss_state = (iss_rem != '0) ? S_SHIFT : S_DONE;
    end

    // Next-state logic: flush beats everything but reset
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        rem_d       = rem_q;
        kind_d      = kind_q;
        sign_d      = sign_q;
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d     = iss_state;
                        result_d    = iss_result;
                        out_valid_d = (iss_state == S_DONE);
                        rem_d       = iss_rem;
                        kind_d      = iss_kind;
                        sign_d      = src0[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    result_d = shift_step(result_q, kind_q, sign_q, cont_d);
                    rem_d    = rem_q - cont_d;
                    if (rem_q == cont_d) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_d     = iss_state;
                            result_d    = iss_result;
                            out_valid_d = (iss_state == S_DONE);
                            rem_d       = iss_rem;
                            kind_d      = iss_kind;
                            sign_d      = src0[WIDTH-1];
                        end else begin
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            kind_q      <= K_SLL;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            rem_q       <= rem_d;
            kind_q      <= kind_d;
            sign_q      <= sign_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ex_logic_shift_unit.sv
// Directed bench for ex_logic_shift_unit at default parameters
// (WIDTH=32, IMM_WIDTH=16, STEP=4).
module tb_ex_logic_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ex_logic_shift_unit #(.WIDTH(32), .IMM_WIDTH(16), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src0      (src0),
        .src1      (src1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge
    task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        src0     = a;
        src1     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from acceptance edge to out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        present(o, a, b);
        wait_valid(lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; src0 = '0; src1 = '0;

        // 1. reset state, bitwise ops, back-to-back issue
        repeat (3) tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_op("and", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000);
        run_op("lui", 4'd4, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h1234_0000);
        run_op("nor", 4'd3, 32'h0, 32'h0, 1, 32'hFFFF_FFFF);
        run_op("or", 4'd1, 32'h1200_0034, 32'h0056_7800, 1, 32'h1256_7834);
        run_op("xor", 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F);
        tick();
        check_eq("idle_after_drain", 32'(out_valid), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // 2. logical shifts, including busy count and amt=0
        check_eq("sll31_in_ready", 32'(in_ready), 32'd1);
        present(4'd5, 32'h1, 32'd31);
        busy_cnt = 0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (busy) busy_cnt++;
        check_eq("sll31_latency", 32'(lat), 32'd8);
        check_eq("sll31_result", result, 32'h8000_0000);
        check_eq("sll31_busy_cycles", 32'(busy_cnt), 32'd8);
        tick();
        run_op("srl4", 4'd6, 32'h8000_0000, 32'd4, 1, 32'h0800_0000);
        run_op("sll_amt0", 4'd5, 32'hDEAD_BEEF, 32'd32, 1, 32'hDEAD_BEEF);
        run_op("srl31", 4'd6, 32'h8000_0000, 32'd31, 8, 32'h0000_0001);

        // 3. arithmetic shifts
        run_op("sra9", 4'd7, 32'h8000_0010, 32'd9, 3, 32'hFFC0_0000);
        run_op("sra28", 4'd7, 32'h7000_0000, 32'd28, 7, 32'h0000_0007);
        run_op("sra5_neg", 4'd7, 32'hF000_0000, 32'd5, 2, 32'hFF80_0000);
        tick();

        // 4. backpressure then same-edge handoff
        out_ready = 1'b0;
        present(4'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_result", result, 32'hAAAA_AAAA);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("handoff_in_ready", 32'(in_ready), 32'd1);
        present(4'd1, 32'h00FF_0000, 32'h0000_00FF);
        check_eq("handoff_valid", 32'(out_valid), 32'd1);
        check_eq("handoff_result", result, 32'h00FF_00FF);
        tick();
        check_eq("handoff_drain", 32'(out_valid), 32'd0);

        // 5. flush mid-shift and flush with a presented op
        present(4'd5, 32'h3, 32'd20);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            tick();
        end
        check_eq("flush_no_valid", 32'(lat), 32'd0);
        run_op("and_after_flush", 4'd0, 32'h1234_5678, 32'h0F0F_0F0F, 1, 32'h0204_0608);
        tick();
        flush = 1'b1;
        in_valid = 1'b1; op = 4'd1; src0 = 32'hFFFF_FFFF; src1 = 32'h0;
        #1;
        check_eq("flush_comb_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_drop_valid", 32'(out_valid), 32'd0);
        check_eq("flush_drop_busy", 32'(busy), 32'd0);
        check_eq("flush_keeps_result", result, 32'h0204_0608);

        // 6. reset mid-shift, reset in DONE, reserved op
        present(4'd7, 32'h8000_0000, 32'd28);
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_shift_valid", 32'(out_valid), 32'd0);
        check_eq("rst_shift_busy", 32'(busy), 32'd0);
        check_eq("rst_shift_result", result, 32'h0);
        rst = 1'b0;
        out_ready = 1'b0;
        present(4'd1, 32'h0000_00F0, 32'h0000_000F);
        check_eq("pre_rst_done_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("rst_done_valid", 32'(out_valid), 32'd0);
        check_eq("rst_done_busy", 32'(busy), 32'd0);
        check_eq("rst_done_result", result, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        run_op("reserved12", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
